// File: rtl/noc_vc_input_port.sv
// noc_vc_input_port: buffered mesh-router input port.
// Holds packets in NUM_VC independent FIFOs. A round-robin arbiter picks one
// VC per cycle, and its head is loaded into a registered output stage together
// with its XY-routed one-hot direction request.
module noc_vc_input_port #(
   parameter int COORD_LENGTH    = 3,
   parameter int PACKET_LENGTH   = 27,
   parameter int NUM_VC          = 2,
   parameter int LOG2_FIFO_DEPTH = 3,
   localparam int VC_W           = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic [COORD_LENGTH-1:0]  my_x,
   input  logic [COORD_LENGTH-1:0]  my_y,
   input  logic                     in_valid,
   input  logic [VC_W-1:0]          in_vc,
   input  logic [PACKET_LENGTH-1:0] in_data,
   output logic [NUM_VC-1:0]        in_ready,
   output logic                     out_valid,
   output logic [PACKET_LENGTH-1:0] out_data,
   output logic [VC_W-1:0]          out_vc,
   output logic [4:0]               out_req,
   input  logic                     out_ready,
   output logic [NUM_VC-1:0]        vc_empty,
   output logic                     err_overflow
);

   localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
   localparam int CNT_W = LOG2_FIFO_DEPTH + 1;
   localparam logic [LOG2_FIFO_DEPTH-1:0] PTR_ONE = 1;
   localparam logic [CNT_W-1:0]           CNT_ONE = 1;
   localparam logic [CNT_W-1:0]           CNT_FULL = DEPTH[CNT_W-1:0];

   localparam logic [4:0] REQ_LOCAL = 5'b00001;
   localparam logic [4:0] REQ_EAST  = 5'b00010;
   localparam logic [4:0] REQ_NORTH = 5'b00100;
   localparam logic [4:0] REQ_WEST  = 5'b01000;
   localparam logic [4:0] REQ_SOUTH = 5'b10000;

   logic [NUM_VC-1:0][PACKET_LENGTH-1:0] head;
   logic [NUM_VC-1:0]                    push;
   logic [NUM_VC-1:0]                    pop;
   logic [NUM_VC-1:0]                    nonempty;
   logic                                 in_vc_ok;
   logic [VC_W-1:0]                      last_grant_reg;
   logic [VC_W-1:0]                      grant;
   logic [VC_W-1:0]                      cand;
   logic                                 grant_any;
   logic                                 load;
   logic [PACKET_LENGTH-1:0]             grant_data;

   // XY dimension-ordered routing: resolve X first, then Y, else deliver locally.
   function automatic logic [4:0] xy_route(input logic [PACKET_LENGTH-1:0] pkt,
                                           input logic [COORD_LENGTH-1:0]  cur_x,
                                           input logic [COORD_LENGTH-1:0]  cur_y);
      logic [COORD_LENGTH-1:0] dx;
      logic [COORD_LENGTH-1:0] dy;
      dx = pkt[PACKET_LENGTH-2 -: COORD_LENGTH];
      dy = pkt[PACKET_LENGTH-2-COORD_LENGTH -: COORD_LENGTH];
      if (dx > cur_x)      return REQ_EAST;
      else if (dx < cur_x) return REQ_WEST;
      else if (dy > cur_y) return REQ_NORTH;
      else if (dy < cur_y) return REQ_SOUTH;
      else                 return REQ_LOCAL;
   endfunction

   // Out-of-range VC numbers are possible when NUM_VC is not a power of two.
   assign in_vc_ok = (32'(in_vc) < NUM_VC);

   generate
      for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
         logic [PACKET_LENGTH-1:0]   mem [DEPTH];
         logic [LOG2_FIFO_DEPTH-1:0] wr_ptr_reg;
         logic [LOG2_FIFO_DEPTH-1:0] rd_ptr_reg;
         logic [CNT_W-1:0]           count_reg;

         // Ready and empty come from the registered count only, so a pop in the
         // same cycle cannot make a full FIFO look writable.
         assign in_ready[gi] = (count_reg != CNT_FULL);
         assign vc_empty[gi] = (count_reg == '0);
         assign nonempty[gi] = ~vc_empty[gi];
         assign push[gi]     = in_valid && in_vc_ok && (in_vc == VC_W'(gi)) && in_ready[gi];
         assign pop[gi]      = load && (grant == VC_W'(gi));
         assign head[gi]     = mem[rd_ptr_reg];

         // Packet storage; contents need no reset because the count gates reads.
         always_ff @(posedge clk) begin
            if (push[gi]) begin
               mem[wr_ptr_reg] <= in_data;
            end
         end

         // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth.
         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
               if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
               if (push[gi] && !pop[gi])      count_reg <= count_reg + CNT_ONE;
               else if (!push[gi] && pop[gi]) count_reg <= count_reg - CNT_ONE;
            end
         end
      end
   endgenerate

   // Round-robin search upward from last grant + 1; walking the candidates from
   // farthest to nearest lets the nearest non-empty VC win.
   always_comb begin
      grant     = last_grant_reg;
      grant_any = 1'b0;
      cand      = '0;
      for (int i = NUM_VC; i >= 1; i--) begin
         cand = VC_W'((int'(last_grant_reg) + i) % NUM_VC);
         if (nonempty[cand]) begin
            grant     = cand;
            grant_any = 1'b1;
         end
      end
   end

   assign grant_data = head[grant];
   assign load       = grant_any && (!out_valid || out_ready);

   // Output stage: load a new head when free or being drained, else hold.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_vc         <= '0;
         out_req        <= '0;
         last_grant_reg <= VC_W'(NUM_VC - 1);
      end else if (load) begin
         out_valid      <= 1'b1;
         out_data       <= grant_data;
         out_vc         <= grant;
         out_req        <= xy_route(grant_data, my_x, my_y);
         last_grant_reg <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky flag for any offered packet that was not stored.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_overflow <= 1'b0;
      end else if (in_valid && (push == '0)) begin
         err_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_vc_input_port.sv
// Bench for noc_vc_input_port: queue-based reference model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_noc_vc_input_port;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        arst_n;
   logic [2:0]  my_x, my_y;
   logic        in_valid;
   logic [0:0]  in_vc;
   logic [26:0] in_data;
   logic [1:0]  in_ready;
   logic        out_valid;
   logic [26:0] out_data;
   logic [0:0]  out_vc;
   logic [4:0]  out_req;
   logic        out_ready;
   logic [1:0]  vc_empty;
   logic        err_overflow;

   // second instance with three VCs, so an out-of-range VC number can be driven
   logic        in_valid2;
   logic [1:0]  in_vc2;
   logic [26:0] in_data2;
   logic [2:0]  in_ready2;
   logic        out_valid2;
   logic [26:0] out_data2;
   logic [1:0]  out_vc2;
   logic [4:0]  out_req2;
   logic        out_ready2;
   logic [2:0]  vc_empty2;
   logic        err_overflow2;

   noc_vc_input_port #(.COORD_LENGTH(3), .PACKET_LENGTH(27), .NUM_VC(2), .LOG2_FIFO_DEPTH(3)) dut (
      .clk(clk), .arst_n(arst_n), .my_x(my_x), .my_y(my_y),
      .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_vc(out_vc), .out_req(out_req),
      .out_ready(out_ready), .vc_empty(vc_empty), .err_overflow(err_overflow)
   );

   noc_vc_input_port #(.COORD_LENGTH(3), .PACKET_LENGTH(27), .NUM_VC(3), .LOG2_FIFO_DEPTH(3)) dut3 (
      .clk(clk), .arst_n(arst_n), .my_x(my_x), .my_y(my_y),
      .in_valid(in_valid2), .in_vc(in_vc2), .in_data(in_data2), .in_ready(in_ready2),
      .out_valid(out_valid2), .out_data(out_data2), .out_vc(out_vc2), .out_req(out_req2),
      .out_ready(out_ready2), .vc_empty(vc_empty2), .err_overflow(err_overflow2)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [26:0] mk(input logic t, input logic [2:0] x, input logic [2:0] y,
                                      input logic [19:0] p);
      return {t, x, y, p};
   endfunction

   function automatic logic [4:0] route_of(input logic [26:0] p);
      if (p[25:23] > my_x)      return 5'b00010;
      else if (p[25:23] < my_x) return 5'b01000;
      else if (p[22:20] > my_y) return 5'b00100;
      else if (p[22:20] < my_y) return 5'b10000;
      return 5'b00001;
   endfunction

   // ---------------- reference model ----------------
   logic [26:0] q0[$];
   logic [26:0] q1[$];
   logic        m_valid;
   logic [26:0] m_data;
   logic        m_vc;
   logic [4:0]  m_req;
   logic        m_err;
   int          m_last;
   int          s0, s1, g, v;
   logic [26:0] pkt_m;
   bit          model_on = 0;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         q0.delete(); q1.delete();
         m_valid = 0; m_data = '0; m_vc = 0; m_req = '0; m_err = 0; m_last = 1;
      end else begin
         s0 = q0.size();
         s1 = q1.size();
         if (!m_valid || out_ready) begin
            g = -1;
            for (int k = 1; k <= 2; k++) begin
               v = (m_last + k) % 2;
               if (g < 0 && ((v == 0) ? s0 : s1) > 0) g = v;
            end
            if (g >= 0) begin
               if (g == 0) pkt_m = q0.pop_front();
               else        pkt_m = q1.pop_front();
               m_valid = 1; m_data = pkt_m; m_vc = g[0]; m_req = route_of(pkt_m); m_last = g;
            end else begin
               m_valid = 0;
            end
         end
         if (in_valid) begin
            if (in_vc == 1'b0 && s0 < 8)      q0.push_back(in_data);
            else if (in_vc == 1'b1 && s1 < 8) q1.push_back(in_data);
            else                              m_err = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (arst_n && model_on) begin
         chk("m_out_valid", out_valid, m_valid);
         if (m_valid) begin
            chk("m_out_data", out_data, m_data);
            chk("m_out_vc", out_vc, m_vc);
            chk("m_out_req", out_req, m_req);
         end
         chk("m_in_ready", in_ready, {q1.size() != 8, q0.size() != 8});
         chk("m_vc_empty", vc_empty, {q1.size() == 0, q0.size() == 0});
         chk("m_err", err_overflow, m_err);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_one(input logic vc, input logic [26:0] d);
      in_vc = vc; in_data = d; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic drain();
      bit done = 0;
      out_ready = 1; in_valid = 0;
      for (int i = 0; i < 30; i++) begin
         if (!done) begin
            @(negedge clk);
            if (vc_empty == 2'b11 && !out_valid) done = 1;
         end
      end
      chk("drain_done", done, 1);
   endtask

   logic [2:0]  sw_x [4] = '{3'd1, 3'd3, 3'd3, 3'd3};
   logic [2:0]  sw_y [4] = '{3'd6, 3'd6, 3'd0, 3'd3};
   logic [4:0]  sw_r [4] = '{5'b01000, 5'b00100, 5'b10000, 5'b00001};
   logic [26:0] exp_q [6];
   logic [26:0] p;

   initial begin
      arst_n = 0; my_x = 3; my_y = 3;
      in_valid = 0; in_vc = 0; in_data = '0; out_ready = 1;
      in_valid2 = 0; in_vc2 = 0; in_data2 = '0; out_ready2 = 0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_req", out_req, 0);
      chk("rst_in_ready", in_ready, 2'b11);
      chk("rst_vc_empty", vc_empty, 2'b11);
      chk("rst_err", err_overflow, 0);
      arst_n = 1; model_on = 1;
      @(negedge clk);

      // out-of-range VC on the three-VC instance
      in_vc2 = 2'd3; in_data2 = mk(1, 3'd2, 3'd2, 20'h0BEEF); in_valid2 = 1;
      @(negedge clk);
      in_valid2 = 0;
      chk("badvc_err", err_overflow2, 1);
      chk("badvc_empty", vc_empty2, 3'b111);
      chk("badvc_ready", in_ready2, 3'b111);
      in_vc2 = 2'd2; in_valid2 = 1;
      @(negedge clk);
      in_valid2 = 0;
      chk("vc2_empty", vc_empty2, 3'b011);
      @(negedge clk);
      chk("vc2_out_valid", out_valid2, 1);
      chk("vc2_out_vc", out_vc2, 2);
      chk("vc2_out_req", out_req2, 5'b01000);

      // single packet latency, dest (5,1) -> EAST
      p = mk(1, 3'd5, 3'd1, 20'h12345);
      push_one(0, p);
      chk("lat_not_yet", out_valid, 0);
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
      chk("lat_req", out_req, 5'b00010);
      chk("lat_vc", out_vc, 0);
      chk("lat_data", out_data, p);
      @(negedge clk);
      chk("lat_clear", out_valid, 0);

      // route sweep
      for (int i = 0; i < 4; i++) begin
         push_one(0, mk(0, sw_x[i], sw_y[i], 20'(i)));
         @(negedge clk);
         chk("route_req", out_req, sw_r[i]);
         @(negedge clk);
      end

      // back-to-back streaming on VC0 (pointer wrap, same-cycle push/pop)
      for (int i = 0; i < 10; i++) push_one(0, mk(1, 3'(i), 3'(7 - i), 20'(100 + i)));
      drain();

      // overflow on VC1 while the output is held
      out_ready = 0;
      push_one(0, mk(0, 3'd1, 3'd1, 20'hAAAAA));
      for (int i = 0; i < 8; i++) push_one(1, mk(1, 3'd4, 3'(i), 20'(200 + i)));
      chk("full_ready", in_ready, 2'b01);
      chk("full_err_before", err_overflow, 0);
      push_one(1, mk(1, 3'd4, 3'd4, 20'hDEAD0));
      chk("ovf_err", err_overflow, 1);
      chk("ovf_ready", in_ready, 2'b01);
      chk("ovf_vc_empty", vc_empty, 2'b01);
      out_ready = 1;
      push_one(1, mk(1, 3'd4, 3'd4, 20'hDEAD1));
      chk("full_pop_same_cycle", in_ready, 2'b11);
      drain();

      // round-robin order
      out_ready = 0;
      for (int i = 0; i < 3; i++) exp_q[2*i]   = mk(0, 3'd3, 3'd3, 20'hA0000 + 20'(i));
      for (int i = 0; i < 3; i++) exp_q[2*i+1] = mk(0, 3'd6, 3'd3, 20'hB0000 + 20'(i));
      for (int i = 0; i < 3; i++) push_one(0, exp_q[2*i]);
      for (int i = 0; i < 3; i++) push_one(1, exp_q[2*i+1]);
      out_ready = 1;
      for (int i = 0; i < 6; i++) begin
         chk("rr_valid", out_valid, 1);
         chk("rr_data", out_data, exp_q[i]);
         @(negedge clk);
      end
      chk("rr_end_valid", out_valid, 0);
      chk("rr_end_empty", vc_empty, 2'b11);

      // reset mid-stream
      out_ready = 0;
      push_one(0, mk(0, 3'd0, 3'd0, 20'h1));
      push_one(0, mk(0, 3'd0, 3'd0, 20'h2));
      push_one(1, mk(0, 3'd0, 3'd0, 20'h3));
      chk("pre_rst_valid", out_valid, 1);
      @(posedge clk);
      #2 arst_n = 0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_req", out_req, 0);
      chk("arst_err", err_overflow, 0);
      chk("arst_vc_empty", vc_empty, 2'b11);
      chk("arst_in_ready", in_ready, 2'b11);
      @(negedge clk);
      arst_n = 1; out_ready = 1;
      p = mk(1, 3'd3, 3'd5, 20'h77777);
      push_one(1, p);
      chk("post_rst_wait", out_valid, 0);
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_vc", out_vc, 1);
      chk("post_rst_data", out_data, p);
      chk("post_rst_req", out_req, 5'b00100);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
